// File: rtl/tpu_pkg.sv
// Shared systolic-array constants and the weight loader state encoding.
package tpu_pkg;

    localparam int WIDTH_HEIGHT = 16;
    localparam int DATA_WIDTH   = WIDTH_HEIGHT * 8;
    localparam int ADDR_WIDTH   = WIDTH_HEIGHT * 8;
    localparam int CNT_W        = $clog2(WIDTH_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/weight_skid_reg.sv
// One-entry holding register that catches a returning weight row while the FIFO is full.
module weight_skid_reg
#(
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_drain,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);
    import tpu_pkg::*;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/weight_fifo_loader.sv
// Streams one weight tile from weight memory into the systolic-array weight FIFO,
// zero-padding to a full tile and pulsing done when the last row is written.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for weight_fifo_enable; all outputs quiet
// LOAD    | issuing reads for rows 0..N and writing returned rows
// PAD     | writing all-zero rows until the tile holds WIDTH_HEIGHT rows
// DONE    | one-cycle done pulse back to the master controller
module weight_fifo_loader
#(
    parameter int WIDTH_HEIGHT = tpu_pkg::WIDTH_HEIGHT,
    parameter int DATA_WIDTH   = WIDTH_HEIGHT * 8,
    parameter int ADDR_WIDTH   = WIDTH_HEIGHT * 8,
    parameter int CNT_W        = $clog2(WIDTH_HEIGHT)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  weight_fifo_enable,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0]      weight_matrix_row_num,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  weight_fifo_done,
    output logic                  busy
);
    import tpu_pkg::*;

    // One extra bit so the counters can hold WIDTH_HEIGHT itself.
    localparam int CW = CNT_W + 1;

    loader_state_t         r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_W-1:0]      r_n;
    logic [CW-1:0]         r_rd_cnt;
    logic [CW-1:0]         r_wr_cnt;
    logic                  r_rd_pend;

    logic                  w_start;
    logic                  w_in_load;
    logic                  w_in_pad;
    logic [CW-1:0]         w_n_ext;
    logic                  w_rd_fire;
    logic                  w_direct_wr;
    logic                  w_skid_load;
    logic                  w_skid_drain;
    logic                  w_pad_wr;
    logic                  w_wr_fire;
    logic                  w_skid_valid;
    logic [DATA_WIDTH-1:0] w_skid_data;

    assign w_start   = (r_state == ST_IDLE) && weight_fifo_enable;
    assign w_in_load = (r_state == ST_LOAD);
    assign w_in_pad  = (r_state == ST_PAD);
    assign w_n_ext   = {1'b0, r_n};

    assign w_rd_fire    = w_in_load && (r_rd_cnt <= w_n_ext) && !fifo_full && !w_skid_valid;
    assign w_skid_load  = w_in_load && r_rd_pend && fifo_full;
    assign w_skid_drain = w_in_load && w_skid_valid && !fifo_full;
    // A held skid row always goes out ahead of any newer returning row.
    assign w_direct_wr  = w_in_load && r_rd_pend && !fifo_full && !w_skid_valid;
    assign w_pad_wr     = w_in_pad && !fifo_full;
    assign w_wr_fire    = w_skid_drain || w_direct_wr || w_pad_wr;

    weight_skid_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_start),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_data  (mem_rd_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_n       <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (weight_fifo_enable) begin
                        r_base   <= base_addr;
                        r_n      <= weight_matrix_row_num;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_rd_pend <= w_rd_fire;
                    if (w_rd_fire)
                        r_rd_cnt <= r_rd_cnt + CW'(1);
                    if (w_wr_fire) begin
                        r_wr_cnt <= r_wr_cnt + CW'(1);
                        // Writing row N means every read has returned and the skid is empty.
                        if (r_wr_cnt == w_n_ext)
                            r_state <= (r_n == CNT_W'(WIDTH_HEIGHT - 1)) ? ST_DONE : ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (w_wr_fire) begin
                        r_wr_cnt <= r_wr_cnt + CW'(1);
                        if (r_wr_cnt == CW'(WIDTH_HEIGHT - 1))
                            r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en    = w_rd_fire;
    assign mem_rd_addr  = w_in_load ? (r_base + {{(ADDR_WIDTH - CW){1'b0}}, r_rd_cnt}) : '0;
    assign fifo_wr_en   = w_wr_fire;
    assign fifo_wr_data = w_skid_drain ? w_skid_data :
                          w_direct_wr  ? mem_rd_data : '0;

    assign weight_fifo_done = (r_state == ST_DONE);
    assign busy             = (r_state != ST_IDLE);

endmodule

// File: doc/weight_fifo_loader.md
# weight_fifo_loader

Loads one weight tile into the weight FIFO that feeds the systolic array. On `weight_fifo_enable` from the master multiply controller, it reads `weight_matrix_row_num+1` rows from weight memory at consecutive addresses starting at `base_addr`. It zero-pads the tile to `WIDTH_HEIGHT` rows, honours FIFO back-pressure, and returns a single-cycle `weight_fifo_done` pulse to the master.

## Interface
- `WIDTH_HEIGHT`, 16 — systolic array dimension; rows per tile.
- `DATA_WIDTH`, `WIDTH_HEIGHT*8` — one weight row (8-bit elements).
- `ADDR_WIDTH`, `WIDTH_HEIGHT*8` — weight memory address width.
- `CNT_W`, `$clog2(WIDTH_HEIGHT)` — row index width.

Ports (reset: reset, synchronous, active-high; clock: clk):
- `clk` in 1 — clock.
- `reset` in 1 — synchronous, active-high.
- `weight_fifo_enable` in 1 — start request; sampled only in IDLE.
- `base_addr` in `ADDR_WIDTH` — address of tile row 0; latched at start.
- `weight_matrix_row_num` in `CNT_W` — last valid row index N (rows 0..N); latched at start.
- `mem_rd_en` out 1 — weight memory read strobe.
- `mem_rd_addr` out `ADDR_WIDTH` — read address.
- `mem_rd_data` in `DATA_WIDTH` — read data, valid exactly 1 cycle after `mem_rd_en`.
- `fifo_full` in 1 — weight FIFO cannot accept a write this cycle.
- `fifo_wr_en` out 1 — FIFO write strobe.
- `fifo_wr_data` out `DATA_WIDTH` — FIFO write data.
- `weight_fifo_done` out 1 — 1-cycle pulse when the tile is fully written.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- **States:** IDLE, LOAD, PAD, DONE.
- **IDLE → LOAD** when `weight_fifo_enable` is sampled high.
  - Latches `base_addr` and N.
  - Clears the read counter `rd_cnt`, the write counter `wr_cnt`, and `skid_valid`.
- **LOAD, read issue:**
  - `mem_rd_en` = (`rd_cnt` ≤ N) & !`fifo_full` & !`skid_valid`.
  - `mem_rd_addr` = `base_addr_q + rd_cnt`, computed modulo 2^`ADDR_WIDTH`.
  - `rd_cnt` increments on each issued read.
- **LOAD, returning data** (cycle after issue):
  - If !`fifo_full`, the data is written to the FIFO directly.
  - Otherwise it is captured in the one-entry skid register and `skid_valid` is set.
  - When `skid_valid` and !`fifo_full`, the skid entry is written and `skid_valid` clears. The skid entry always drains before any new data.
- `wr_cnt` increments on every `fifo_wr_en`.
- **LOAD exit:** when `wr_cnt` reaches N+1 (no read outstanding, skid empty):
  - go to PAD if N < `WIDTH_HEIGHT-1`;
  - go directly to DONE if N = `WIDTH_HEIGHT-1`.
- **PAD:** writes all-zero rows while !`fifo_full` until `wr_cnt` = `WIDTH_HEIGHT`, then go to DONE.
- **DONE:** `weight_fifo_done` = 1 for exactly one cycle, then go to IDLE.
- `weight_fifo_enable` is ignored while `busy`. A request in the DONE cycle is lost.
- **Reset:**
  - Outputs: `mem_rd_en`, `mem_rd_addr`, `fifo_wr_en`, `fifo_wr_data`, `weight_fifo_done` and `busy` are all 0.
  - Internal: state is IDLE, counters are 0, skid is empty.
- **Reset mid-tile:** aborts immediately, with no done pulse. Rows already written stay in the FIFO; the FIFO is reset by its own reset.
- The tile always contains exactly `WIDTH_HEIGHT` FIFO writes, in ascending row order.

## Timing
- Enable sampled at cycle 0. With `fifo_full` = 0 throughout:
  - reads occur in cycles 1..N+1;
  - memory writes occur in cycles 2..N+2;
  - pad writes occur in cycles N+3..`WIDTH_HEIGHT`+1;
  - `weight_fifo_done` is high in cycle `WIDTH_HEIGHT`+2.
- Latency is independent of N.
- Each `fifo_full` cycle adds one cycle of latency per blocked write. A skid drain adds at most one extra bubble before the next read.
- `mem_rd_*` and `fifo_wr_*` are combinational from registered state, counters, skid contents, `fifo_full` and `mem_rd_data`. They never depend combinationally on `weight_fifo_enable`.
- Because the done output is a pulse, the master's done-wait state cannot see a stale done from a previous tile.

## Structure
- The shared package `tpu_pkg` holds:
  - `WIDTH_HEIGHT` and the derived widths;
  - the 2-bit loader state encoding (IDLE=0, LOAD=1, PAD=2, DONE=3).
- One sub-module, `weight_skid_reg`: a one-entry `DATA_WIDTH` holding register with load, drain and valid.

## Test plan
- N=15, `base_addr`=0x40, no full:
  - reads at 0x40..0x4F in cycles 1..16;
  - 16 writes matching memory;
  - done in cycle 18 only.
- N=3, `base_addr`=0x100:
  - 4 memory rows, then 12 zero rows;
  - done in cycle 18;
  - `busy` high in cycles 1..18.
- N=7, `fifo_full` held high in cycles 3..5:
  - row 1 is captured in skid and written in cycle 6 before row 2;
  - no read is issued while full or skid is valid;
  - 16 writes total, in order;
  - done delayed by 4 cycles vs. no-stall.
- `base_addr` = 2^`ADDR_WIDTH`−2, N=3 → read addresses wrap to …FE, …FF, 0, 1.
- `reset` asserted in cycle 5 of an N=15 tile:
  - all outputs 0 the next cycle;
  - no done pulse;
  - a new enable starts cleanly from row 0.
- `weight_fifo_enable` re-pulsed while busy → no effect; exactly one done per accepted start.
